// File: rtl/time_set_editor.sv
// Time-set editor: debounces mode/next/up buttons and lets the user edit an
// hh:mm:ss value digit by digit, then strobes load for one clk on commit.
//
// Ports:
//   clk, rstn            system clock, asynchronous active-low reset
//   clken                debounce sample tick (one clk wide)
//   btn_mode/next/up     raw active-high push-buttons
//   hr1..sec0            edited BCD digits (registered)
//   load                 one-clk strobe on commit (first clk back in IDLE)
//   editing              high while in EDIT
//   edit_sel             one-hot selected digit, [5]=hr1 .. [0]=sec0, zero in IDLE
module time_set_editor #(
    parameter int unsigned DEBOUNCE_TICKS = 20,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       clken,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_up,
    output logic [3:0] hr1,
    output logic [3:0] hr0,
    output logic [3:0] min1,
    output logic [3:0] min0,
    output logic [3:0] sec1,
    output logic [3:0] sec0,
    output logic       load,
    output logic       editing,
    output logic [5:0] edit_sel
);

    localparam int unsigned NBTN  = 3;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned SEL_W = 6;

    typedef enum logic {IDLE, EDIT} state_t;

    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] db_level;
    logic [NBTN-1:0] db_prev;
    logic [NBTN-1:0] press;

    assign btn_raw = {btn_up, btn_next, btn_mode};

    // Per-button synchroniser and sample-counting debouncer
    for (genvar g = 0; g < NBTN; g++) begin : g_btn
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CNT_W-1:0]       cnt_q;
        logic                   db_q;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                sync_q <= '0;
                cnt_q  <= '0;
                db_q   <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[g]};
                if (clken) begin
                    if (sync_q[SYNC_STAGES-1] != db_q) begin
                        if (cnt_q == CNT_W'(DEBOUNCE_TICKS - 1)) begin
                            db_q  <= sync_q[SYNC_STAGES-1];
                            cnt_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
            end
        end

        assign db_level[g] = db_q;
    end

    // Rising edge of the debounced level becomes a registered one-clk press
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            db_prev <= '0;
            press   <= '0;
        end else begin
            db_prev <= db_level;
            press   <= db_level & ~db_prev;
        end
    end

    logic press_mode, press_next, press_up;
    assign press_mode = press[0];
    assign press_next = press[1];
    assign press_up   = press[2];

    function automatic logic [3:0] inc_wrap(input logic [3:0] d, input logic [3:0] max);
        return (d >= max) ? 4'd0 : 4'(d + 4'd1);
    endfunction

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_d;
    logic             load_d;
    logic [3:0]       hr1_d, hr0_d, min1_d, min0_d, sec1_d, sec0_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            edit_sel <= '0;
            load     <= 1'b0;
            editing  <= 1'b0;
            hr1      <= '0;
            hr0      <= '0;
            min1     <= '0;
            min0     <= '0;
            sec1     <= '0;
            sec0     <= '0;
        end else begin
            state_q  <= state_d;
            edit_sel <= sel_d;
            load     <= load_d;
            editing  <= (state_d == EDIT);
            hr1      <= hr1_d;
            hr0      <= hr0_d;
            min1     <= min1_d;
            min0     <= min0_d;
            sec1     <= sec1_d;
            sec0     <= sec0_d;
        end
    end

    // Next state, selection and digit update; priority mode > next > up
    always_comb begin
        state_d = state_q;
        sel_d   = edit_sel;
        load_d  = 1'b0;
        hr1_d   = hr1;
        hr0_d   = hr0;
        min1_d  = min1;
        min0_d  = min0;
        sec1_d  = sec1;
        sec0_d  = sec0;
        case (state_q)
            IDLE: begin
                if (press_mode) begin
                    state_d = EDIT;
                    sel_d   = 6'b100000;
                end
            end
            EDIT: begin
                if (press_mode) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    load_d  = 1'b1;
                end else if (press_next) begin
                    sel_d = {edit_sel[0], edit_sel[SEL_W-1:1]};
                end else if (press_up) begin
                    if (edit_sel[5]) begin
                        hr1_d = inc_wrap(hr1, 4'd2);
                        // Keep the hour legal when the tens digit reaches 2
                        if (hr1_d == 4'd2 && hr0 > 4'd3) begin
                            hr0_d = 4'd0;
                        end
                    end else if (edit_sel[4]) begin
                        hr0_d = inc_wrap(hr0, (hr1 == 4'd2) ? 4'd3 : 4'd9);
                    end else if (edit_sel[3]) begin
                        min1_d = inc_wrap(min1, 4'd5);
                    end else if (edit_sel[2]) begin
                        min0_d = inc_wrap(min0, 4'd9);
                    end else if (edit_sel[1]) begin
                        sec1_d = inc_wrap(sec1, 4'd5);
                    end else if (edit_sel[0]) begin
                        sec0_d = inc_wrap(sec0, 4'd9);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_time_set_editor.sv
// Directed bench for time_set_editor: debounce, edit path, clamp, wrap,
// press priority and reset mid-edit.
module tb_time_set_editor;

    logic       clk = 1'b0;
    logic       rstn;
    logic       clken = 1'b0;
    logic       btn_mode, btn_next, btn_up;
    logic [3:0] hr1, hr0, min1, min0, sec1, sec0;
    logic       load, editing;
    logic [5:0] edit_sel;

    int checks = 0;
    int errors = 0;
    int load_cnt = 0;
    int illegal_cnt = 0;
    int load_snap;

    time_set_editor dut (
        .clk      (clk),
        .rstn     (rstn),
        .clken    (clken),
        .btn_mode (btn_mode),
        .btn_next (btn_next),
        .btn_up   (btn_up),
        .hr1      (hr1),
        .hr0      (hr0),
        .min1     (min1),
        .min0     (min0),
        .sec1     (sec1),
        .sec0     (sec0),
        .load     (load),
        .editing  (editing),
        .edit_sel (edit_sel)
    );

    always #5 clk = ~clk;

    // Sample tick: high for one full clk out of every two
    always @(negedge clk) clken = ~clken;

    // Count load cycles and any out-of-range time value
    always @(negedge clk) begin
        if (load) load_cnt++;
        if (rstn && (hr1 > 4'd2 || (hr1 == 4'd2 && hr0 > 4'd3) || hr0 > 4'd9 ||
                     min1 > 4'd5 || min0 > 4'd9 || sec1 > 4'd5 || sec0 > 4'd9))
            illegal_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold the selected buttons for 25 samples, release for 25 samples
    task automatic press(input logic m, input logic n, input logic u);
        btn_mode = m;
        btn_next = n;
        btn_up   = u;
        repeat (50) @(posedge clk);
        btn_mode = 1'b0;
        btn_next = 1'b0;
        btn_up   = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic press_n(input int which, input int count);
        for (int i = 0; i < count; i++) begin
            if (which == 0) press(1'b1, 1'b0, 1'b0);
            else if (which == 1) press(1'b0, 1'b1, 1'b0);
            else press(1'b0, 1'b0, 1'b1);
        end
    endtask

    function automatic logic [23:0] digits();
        return {hr1, hr0, min1, min0, sec1, sec0};
    endfunction

    initial begin
        rstn = 1'b0;
        btn_mode = 1'b0;
        btn_next = 1'b0;
        btn_up = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Reset state
        check("reset_digits", 32'(digits()), 32'h0);
        check("reset_editing", 32'(editing), 32'h0);
        check("reset_sel", 32'(edit_sel), 32'h0);
        check("reset_load", 32'(load), 32'h0);

        // Up and next in IDLE are ignored
        press_n(2, 1);
        press_n(1, 1);
        check("idle_ignore_digits", 32'(digits()), 32'h0);
        check("idle_ignore_editing", 32'(editing), 32'h0);

        // Edit path: hr1=2, hr0 wraps 3->0 and ends at 1, commit 21:00:00
        press_n(0, 1);
        check("enter_editing", 32'(editing), 32'h1);
        check("enter_sel", 32'(edit_sel), 32'h20);
        press_n(2, 2);
        check("hr1_two", 32'(hr1), 32'h2);
        press_n(1, 1);
        check("sel_hr0", 32'(edit_sel), 32'h10);
        press_n(2, 3);
        check("hr0_three", 32'(hr0), 32'h3);
        press_n(2, 2);
        check("hr0_wrapped", 32'(hr0), 32'h1);
        press_n(0, 1);
        check("commit_digits", 32'(digits()), 32'h210000);
        check("commit_load_once", 32'(load_cnt), 32'h1);
        check("commit_editing", 32'(editing), 32'h0);
        check("commit_sel", 32'(edit_sel), 32'h0);

        // Bounce on up while editing hr1: one increment, 2 -> 0
        press_n(0, 1);
        for (int s = 0; s < 10; s++) begin
            btn_up = ((s / 3) % 2 == 0);
            repeat (2) @(posedge clk);
        end
        btn_up = 1'b1;
        repeat (50) @(posedge clk);
        btn_up = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("bounce_hr1", 32'(hr1), 32'h0);
        check("bounce_hr0", 32'(hr0), 32'h1);

        // Clamp: hr1=1, hr0=7, then up on hr1 forces hr0 to 0
        press_n(2, 1);
        press_n(1, 1);
        press_n(2, 6);
        check("hr0_seven", 32'(hr0), 32'h7);
        press_n(1, 5);
        check("sel_back_hr1", 32'(edit_sel), 32'h20);
        press_n(2, 1);
        check("clamp_hr1", 32'(hr1), 32'h2);
        check("clamp_hr0", 32'(hr0), 32'h0);

        // Wrap: six nexts return to hr1; sec0 up x10 returns to 0
        press_n(1, 6);
        check("sel_wrap", 32'(edit_sel), 32'h20);
        press_n(1, 5);
        check("sel_sec0", 32'(edit_sel), 32'h01);
        press_n(2, 9);
        check("sec0_nine", 32'(sec0), 32'h9);
        press_n(2, 1);
        check("sec0_wrap", 32'(sec0), 32'h0);

        // Priority: mode and up in the same clk commits without incrementing
        press_n(2, 1);
        check("sec0_one", 32'(sec0), 32'h1);
        press(1'b1, 1'b0, 1'b1);
        check("prio_editing", 32'(editing), 32'h0);
        check("prio_digits", 32'(digits()), 32'h200001);
        check("prio_load", 32'(load_cnt), 32'h2);

        // Reset mid-edit: min0=7, then reset gives zeros and no load
        press_n(0, 1);
        press_n(1, 3);
        check("sel_min0", 32'(edit_sel), 32'h04);
        press_n(2, 7);
        check("min0_seven", 32'(min0), 32'h7);
        load_snap = load_cnt;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("rst_digits", 32'(digits()), 32'h0);
        check("rst_editing", 32'(editing), 32'h0);
        check("rst_sel", 32'(edit_sel), 32'h0);
        repeat (10) @(negedge clk);
        check("rst_no_load", 32'(load_cnt), 32'(load_snap));

        check("always_legal", 32'(illegal_cnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
